// File: rtl/cpu_pkg.sv
// Shared control encodings: FSM states, opcode classes, branch conditions, immgen selects, trap causes.
// The datapath imports the same constants so both sides decode the instruction identically.
package cpu_pkg;
    typedef enum logic [2:0] {
        ST_HALT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    localparam logic [3:0] CL_RALU   = 4'd0;
    localparam logic [3:0] CL_IALU   = 4'd1;
    localparam logic [3:0] CL_LOAD   = 4'd2;
    localparam logic [3:0] CL_STORE  = 4'd3;
    localparam logic [3:0] CL_BRANCH = 4'd4;
    localparam logic [3:0] CL_JUMP   = 4'd5;
    localparam logic [3:0] CL_HALT   = 4'd6;

    localparam logic [2:0] COND_AL  = 3'b000;
    localparam logic [2:0] COND_EQ  = 3'b001;
    localparam logic [2:0] COND_NE  = 3'b010;
    localparam logic [2:0] COND_LT  = 3'b011;
    localparam logic [2:0] COND_GE  = 3'b100;
    localparam logic [2:0] COND_CS  = 3'b101;
    localparam logic [2:0] COND_CC  = 3'b110;
    localparam logic [2:0] COND_NV  = 3'b111;

    localparam logic [1:0] IMM_IALU = 2'b00;
    localparam logic [1:0] IMM_LS   = 2'b01;
    localparam logic [1:0] IMM_BR   = 2'b10;
    localparam logic [1:0] IMM_JMP  = 2'b11;

    localparam logic [1:0] TRAP_NONE     = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL  = 2'b01;
    localparam logic [1:0] TRAP_FETCH_TO = 2'b10;
    localparam logic [1:0] TRAP_DATA_TO  = 2'b11;

    function automatic logic is_legal(input logic [3:0] cls);
        return cls <= CL_HALT;
    endfunction
endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation from flags {rsv,V,C,N,Z}; zero latency.
module branch_cond_eval
    import cpu_pkg::*;
(
    input  logic [2:0] i_cond,
    input  logic [4:0] i_status,
    output logic       o_taken
);
    logic w_z, w_n, w_c, w_v;

    assign w_z = i_status[0];
    assign w_n = i_status[1];
    assign w_c = i_status[2];
    assign w_v = i_status[3];

    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            COND_AL: o_taken = 1'b1;
            COND_EQ: o_taken = w_z;
            COND_NE: o_taken = ~w_z;
            COND_LT: o_taken = w_n ^ w_v;
            COND_GE: o_taken = ~(w_n ^ w_v);
            COND_CS: o_taken = w_c;
            COND_CC: o_taken = ~w_c;
            default: o_taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB); 3-5 cycles per instruction at zero wait.
// Stalls in FETCH/MEM until mem_ready, trapping after TIMEOUT consecutive idle cycles.
module mc_control_unit
    import cpu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [XLEN-1:0]  instr,
    input  logic [4:0]       status,
    input  logic             mem_ready,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pcsrc,
    output logic             alusrc,
    output logic [3:0]       aluop,
    output logic             mem_req,
    output logic             memrw,
    output logic             wb,
    output logic             regrw,
    output logic [1:0]       immgen_ctrl,
    output logic             halted,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired
);
    state_t           r_state;
    logic [TO_W-1:0]  r_wait;
    logic [1:0]       r_cause;
    logic [CNT_W-1:0] r_retired;

    logic [3:0] w_cls;
    logic [2:0] w_cond;
    logic       w_taken;
    logic       w_timeout;
    logic       w_decoded;

    assign w_cls     = instr[XLEN-1:XLEN-4];
    assign w_cond    = instr[XLEN-5:XLEN-7];
    // A ready on the final wait cycle completes the access instead of trapping.
    assign w_timeout = ~mem_ready && (r_wait == TO_W'(TIMEOUT - 1));

    branch_cond_eval u_cond (
        .i_cond   (w_cond),
        .i_status (status),
        .o_taken  (w_taken)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_HALT;
            r_wait    <= '0;
            r_cause   <= TRAP_NONE;
            r_retired <= '0;
        end else begin
            if (r_state == ST_FETCH || r_state == ST_MEM)
                r_wait <= mem_ready ? '0 : r_wait + TO_W'(1);
            else
                r_wait <= '0;

            case (r_state)
                ST_HALT: if (run) r_state <= ST_FETCH;
                ST_FETCH: begin
                    if (mem_ready) r_state <= ST_DECODE;
                    else if (w_timeout) begin
                        r_state <= ST_TRAP;
                        r_cause <= TRAP_FETCH_TO;
                    end
                end
                ST_DECODE: begin
                    if (!is_legal(w_cls)) begin
                        r_state <= ST_TRAP;
                        r_cause <= TRAP_ILLEGAL;
                    end else if (w_cls == CL_HALT) begin
                        r_state   <= ST_HALT;
                        r_retired <= r_retired + CNT_W'(1);
                    end else begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (w_cls == CL_LOAD || w_cls == CL_STORE) begin
                        r_state <= ST_MEM;
                    end else if (w_cls == CL_BRANCH || w_cls == CL_JUMP) begin
                        r_state   <= ST_FETCH;
                        r_retired <= r_retired + CNT_W'(1);
                    end else begin
                        r_state <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        if (w_cls == CL_STORE) begin
                            r_state   <= ST_FETCH;
                            r_retired <= r_retired + CNT_W'(1);
                        end else begin
                            r_state <= ST_WB;
                        end
                    end else if (w_timeout) begin
                        r_state <= ST_TRAP;
                        r_cause <= TRAP_DATA_TO;
                    end
                end
                ST_WB: begin
                    r_state   <= run ? ST_FETCH : ST_HALT;
                    r_retired <= r_retired + CNT_W'(1);
                end
                ST_TRAP: r_state <= ST_TRAP;
                default: r_state <= ST_HALT;
            endcase
        end
    end

    assign w_decoded = (r_state == ST_DECODE) || (r_state == ST_EXEC) ||
                       (r_state == ST_MEM)    || (r_state == ST_WB);

    always_comb begin
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pcsrc       = 1'b0;
        alusrc      = 1'b0;
        aluop       = 4'b0000;
        mem_req     = 1'b0;
        memrw       = 1'b0;
        wb          = 1'b0;
        regrw       = 1'b0;
        immgen_ctrl = IMM_IALU;
        // Instruction-field decode is only meaningful once IR holds the fetched word.
        if (w_decoded) begin
            case (w_cls)
                CL_RALU: aluop = instr[3:0];
                CL_IALU: begin
                    aluop  = instr[3:0];
                    alusrc = 1'b1;
                end
                CL_LOAD, CL_STORE: begin
                    alusrc      = 1'b1;
                    immgen_ctrl = IMM_LS;
                end
                CL_BRANCH: begin
                    alusrc      = 1'b1;
                    immgen_ctrl = IMM_BR;
                end
                CL_JUMP: begin
                    alusrc      = 1'b1;
                    immgen_ctrl = IMM_JMP;
                end
                default: ;
            endcase
        end
        case (r_state)
            ST_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
                pc_we   = mem_ready;
            end
            ST_EXEC: begin
                if (w_cls == CL_BRANCH) begin
                    pc_we = 1'b1;
                    pcsrc = w_taken;
                end else if (w_cls == CL_JUMP) begin
                    pc_we = 1'b1;
                    pcsrc = 1'b1;
                    regrw = 1'b1;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                memrw   = (w_cls == CL_STORE);
            end
            ST_WB: begin
                regrw = 1'b1;
                wb    = (w_cls == CL_LOAD);
            end
            default: ;
        endcase
    end

    assign halted     = (r_state == ST_HALT);
    assign trap       = (r_state == ST_TRAP);
    assign trap_cause = r_cause;
    assign retired    = r_retired;
endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: stimulus pushes per-cycle expected outputs, a negedge monitor pops and compares.
module tb_mc_control_unit;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic [31:0]   instr = 32'h0;
    logic [4:0]    status = 5'h0;
    logic          mem_ready = 1'b0;
    logic          ir_we, pc_we, pcsrc, alusrc, mem_req, memrw, wb, regrw, halted, trap;
    logic [3:0]    aluop;
    logic [1:0]    immgen_ctrl, trap_cause;
    logic [CW-1:0] retired;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string         nm;
        logic [17:0]   e;
        logic [CW-1:0] r;
    } exp_t;
    exp_t q[$];

    mc_control_unit #(.XLEN(32), .CNT_W(CW), .TIMEOUT(15), .TO_W(4)) dut (
        .clk(clk), .rst(rst), .run(run), .instr(instr), .status(status), .mem_ready(mem_ready),
        .ir_we(ir_we), .pc_we(pc_we), .pcsrc(pcsrc), .alusrc(alusrc), .aluop(aluop),
        .mem_req(mem_req), .memrw(memrw), .wb(wb), .regrw(regrw), .immgen_ctrl(immgen_ctrl),
        .halted(halted), .trap(trap), .trap_cause(trap_cause), .retired(retired)
    );

    always #5 clk = ~clk;

    logic [21:0] obs;
    assign obs = {ir_we, pc_we, pcsrc, alusrc, aluop, mem_req, memrw, wb, regrw,
                  immgen_ctrl, halted, trap, trap_cause, retired};

    function automatic logic [17:0] mk(input logic ir, input logic pc, input logic pcs, input logic asrc,
                                       input logic [3:0] aop, input logic mreq, input logic mrw,
                                       input logic wbv, input logic rrw, input logic [1:0] imm,
                                       input logic hlt, input logic trp, input logic [1:0] cs);
        return {ir, pc, pcs, asrc, aop, mreq, mrw, wbv, rrw, imm, hlt, trp, cs};
    endfunction

    task automatic chk(input string nm, input logic [21:0] got, input logic [21:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            chk(x.nm, obs, {x.e, x.r});
        end
    end

    task automatic step(input string nm, input logic rn, input logic rdy, input logic [4:0] st,
                        input logic [31:0] ins, input logic [17:0] e, input logic [CW-1:0] r);
        exp_t x;
        @(posedge clk);
        #1;
        run = rn; mem_ready = rdy; status = st; instr = ins;
        x.nm = nm; x.e = e; x.r = r;
        q.push_back(x);
    endtask

    logic [17:0] e_h, e_frdy, e_fw;

    task automatic do_reset(input string nm);
        @(posedge clk);
        #1;
        rst = 1'b1; run = 1'b0; mem_ready = 1'b0;
        #1;
        chk(nm, obs, {e_h, 4'd0});
        #1;
        rst = 1'b0;
    endtask

    logic [31:0]   br_ins [6];
    logic [4:0]    br_st  [6];
    logic          br_pcs [6];
    logic [CW-1:0] er;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        e_h    = mk(0,0,0,0,4'h0,0,0,0,0,2'b00,1,0,2'b00);
        e_frdy = mk(1,1,0,0,4'h0,1,0,0,0,2'b00,0,0,2'b00);
        e_fw   = mk(0,0,0,0,4'h0,1,0,0,0,2'b00,0,0,2'b00);
        br_ins = '{32'h4200_0000, 32'h4200_0000, 32'h4600_0000, 32'h4E00_0000, 32'h4400_0000, 32'h4A00_0000};
        br_st  = '{5'b00001,      5'b00000,      5'b00010,      5'b11111,      5'b00000,      5'b00100};
        br_pcs = '{1'b1,          1'b0,          1'b1,          1'b0,          1'b1,          1'b1};

        #2;
        chk("reset_state", obs, {e_h, 4'd0});
        @(posedge clk);
        #1 rst = 1'b0;

        // R-type: F, D, E, W
        step("r_halt",  1,1,0,32'h0000_0003, e_h, 0);
        step("r_fetch", 1,1,0,32'h0000_0003, e_frdy, 0);
        step("r_dec",   1,1,0,32'h0000_0003, mk(0,0,0,0,4'h3,0,0,0,0,2'b00,0,0,2'b00), 0);
        step("r_exec",  1,1,0,32'h0000_0003, mk(0,0,0,0,4'h3,0,0,0,0,2'b00,0,0,2'b00), 0);
        step("r_wb",    1,1,0,32'h0000_0003, mk(0,0,0,0,4'h3,0,0,0,1,2'b00,0,0,2'b00), 0);

        // LOAD with three wait cycles in MEM
        step("ld_fetch", 1,1,0,32'h2000_0000, e_frdy, 1);
        step("ld_dec",   1,1,0,32'h2000_0000, mk(0,0,0,1,4'h0,0,0,0,0,2'b01,0,0,2'b00), 1);
        step("ld_exec",  1,1,0,32'h2000_0000, mk(0,0,0,1,4'h0,0,0,0,0,2'b01,0,0,2'b00), 1);
        for (int i = 0; i < 3; i++)
            step("ld_mem_wait", 1,0,0,32'h2000_0000, mk(0,0,0,1,4'h0,1,0,0,0,2'b01,0,0,2'b00), 1);
        step("ld_mem_rdy", 1,1,0,32'h2000_0000, mk(0,0,0,1,4'h0,1,0,0,0,2'b01,0,0,2'b00), 1);
        step("ld_wb",      1,1,0,32'h2000_0000, mk(0,0,0,1,4'h0,0,0,1,1,2'b01,0,0,2'b00), 1);

        // STORE
        step("st_fetch", 1,1,0,32'h3000_0000, e_frdy, 2);
        step("st_dec",   1,1,0,32'h3000_0000, mk(0,0,0,1,4'h0,0,0,0,0,2'b01,0,0,2'b00), 2);
        step("st_exec",  1,1,0,32'h3000_0000, mk(0,0,0,1,4'h0,0,0,0,0,2'b01,0,0,2'b00), 2);
        step("st_mem",   1,1,0,32'h3000_0000, mk(0,0,0,1,4'h0,1,1,0,0,2'b01,0,0,2'b00), 2);

        // Branches over several conditions
        er = 3;
        for (int i = 0; i < 6; i++) begin
            step("br_fetch", 1,1,br_st[i],br_ins[i], e_frdy, er);
            step("br_dec",   1,1,br_st[i],br_ins[i], mk(0,0,0,1,4'h0,0,0,0,0,2'b10,0,0,2'b00), er);
            step("br_exec",  1,1,br_st[i],br_ins[i], mk(0,1,br_pcs[i],1,4'h0,0,0,0,0,2'b10,0,0,2'b00), er);
            er = er + 1'b1;
        end

        // JUMP with link
        step("jmp_fetch", 1,1,0,32'h5000_0000, e_frdy, 9);
        step("jmp_dec",   1,1,0,32'h5000_0000, mk(0,0,0,1,4'h0,0,0,0,0,2'b11,0,0,2'b00), 9);
        step("jmp_exec",  1,1,0,32'h5000_0000, mk(0,1,1,1,4'h0,0,0,0,1,2'b11,0,0,2'b00), 9);

        // I-ALU, run dropped in WB -> HALT
        step("i_fetch", 1,1,0,32'h1000_000A, e_frdy, 10);
        step("i_dec",   0,1,0,32'h1000_000A, mk(0,0,0,1,4'hA,0,0,0,0,2'b00,0,0,2'b00), 10);
        step("i_exec",  0,1,0,32'h1000_000A, mk(0,0,0,1,4'hA,0,0,0,0,2'b00,0,0,2'b00), 10);
        step("i_wb",    0,1,0,32'h1000_000A, mk(0,0,0,1,4'hA,0,0,0,1,2'b00,0,0,2'b00), 10);
        step("idle_halt0", 0,1,0,32'h1000_000A, e_h, 11);
        step("idle_halt1", 1,1,0,32'h1000_000A, e_h, 11);

        // HALT-class instruction retires and halts
        step("hc_fetch", 0,1,0,32'h6000_0000, e_frdy, 11);
        step("hc_dec",   0,1,0,32'h6000_0000, mk(0,0,0,0,4'h0,0,0,0,0,2'b00,0,0,2'b00), 11);
        step("hc_halt0", 0,1,0,32'h6000_0000, e_h, 12);
        step("hc_halt1", 1,1,0,32'h6000_0000, e_h, 12);

        // Retire counter wrap
        er = 12;
        for (int i = 0; i < 4; i++) begin
            step("wr_fetch", 1,1,0,32'h4E00_0000, e_frdy, er);
            step("wr_dec",   1,1,0,32'h4E00_0000, mk(0,0,0,1,4'h0,0,0,0,0,2'b10,0,0,2'b00), er);
            step("wr_exec",  1,1,0,32'h4E00_0000, mk(0,1,0,1,4'h0,0,0,0,0,2'b10,0,0,2'b00), er);
            er = er + 1'b1;
        end

        // Fetch ready arrives on the 15th wait cycle: no trap
        for (int i = 0; i < 14; i++)
            step("f15_wait", 1,0,0,32'h0000_0005, e_fw, 0);
        step("f15_rdy",  1,1,0,32'h0000_0005, e_frdy, 0);
        step("f15_dec",  1,1,0,32'h0000_0005, mk(0,0,0,0,4'h5,0,0,0,0,2'b00,0,0,2'b00), 0);
        step("f15_exec", 1,1,0,32'h0000_0005, mk(0,0,0,0,4'h5,0,0,0,0,2'b00,0,0,2'b00), 0);
        step("f15_wb",   1,1,0,32'h0000_0005, mk(0,0,0,0,4'h5,0,0,0,1,2'b00,0,0,2'b00), 0);

        // Fetch timeout trap
        for (int i = 0; i < 15; i++)
            step("fto_wait", 1,0,0,32'h0000_0005, e_fw, 1);
        for (int i = 0; i < 3; i++)
            step("fto_trap", 1,1,0,32'h0000_0005, mk(0,0,0,0,4'h0,0,0,0,0,2'b00,0,1,2'b10), 1);
        do_reset("rst_from_trap");

        // Illegal opcode trap, retired preserved
        step("il_halt",   1,1,0,32'h5000_0000, e_h, 0);
        step("il_jfetch", 1,1,0,32'h5000_0000, e_frdy, 0);
        step("il_jdec",   1,1,0,32'h5000_0000, mk(0,0,0,1,4'h0,0,0,0,0,2'b11,0,0,2'b00), 0);
        step("il_jexec",  1,1,0,32'h5000_0000, mk(0,1,1,1,4'h0,0,0,0,1,2'b11,0,0,2'b00), 0);
        step("il_fetch",  1,1,0,32'hF000_0000, e_frdy, 1);
        step("il_dec",    1,1,0,32'hF000_0000, mk(0,0,0,0,4'h0,0,0,0,0,2'b00,0,0,2'b00), 1);
        for (int i = 0; i < 3; i++)
            step("il_trap", 1,1,5'h1F,32'hF000_0000, mk(0,0,0,0,4'h0,0,0,0,0,2'b00,0,1,2'b01), 1);
        do_reset("rst_from_illegal");

        // Data timeout trap
        step("dto_halt",  1,1,0,32'h2000_0000, e_h, 0);
        step("dto_fetch", 1,1,0,32'h2000_0000, e_frdy, 0);
        step("dto_dec",   1,1,0,32'h2000_0000, mk(0,0,0,1,4'h0,0,0,0,0,2'b01,0,0,2'b00), 0);
        step("dto_exec",  1,0,0,32'h2000_0000, mk(0,0,0,1,4'h0,0,0,0,0,2'b01,0,0,2'b00), 0);
        for (int i = 0; i < 15; i++)
            step("dto_wait", 1,0,0,32'h2000_0000, mk(0,0,0,1,4'h0,1,0,0,0,2'b01,0,0,2'b00), 0);
        for (int i = 0; i < 2; i++)
            step("dto_trap", 1,1,0,32'h2000_0000, mk(0,0,0,0,4'h0,0,0,0,0,2'b00,0,1,2'b11), 0);
        do_reset("rst_from_dto");

        // Asynchronous reset in the middle of a MEM wait
        step("ar_halt",    1,1,0,32'h3000_0000, e_h, 0);
        step("ar_sfetch",  1,1,0,32'h3000_0000, e_frdy, 0);
        step("ar_sdec",    1,1,0,32'h3000_0000, mk(0,0,0,1,4'h0,0,0,0,0,2'b01,0,0,2'b00), 0);
        step("ar_sexec",   1,1,0,32'h3000_0000, mk(0,0,0,1,4'h0,0,0,0,0,2'b01,0,0,2'b00), 0);
        step("ar_smem",    1,1,0,32'h3000_0000, mk(0,0,0,1,4'h0,1,1,0,0,2'b01,0,0,2'b00), 0);
        step("ar_lfetch",  1,1,0,32'h2000_0000, e_frdy, 1);
        step("ar_ldec",    1,1,0,32'h2000_0000, mk(0,0,0,1,4'h0,0,0,0,0,2'b01,0,0,2'b00), 1);
        step("ar_lexec",   1,0,0,32'h2000_0000, mk(0,0,0,1,4'h0,0,0,0,0,2'b01,0,0,2'b00), 1);
        step("ar_lmem",    1,0,0,32'h2000_0000, mk(0,0,0,1,4'h0,1,0,0,0,2'b01,0,0,2'b00), 1);
        #7;
        rst = 1'b1; run = 1'b0;
        #1;
        chk("rst_mid_mem", obs, {e_h, 4'd0});
        @(posedge clk);
        #1 rst = 1'b0;
        step("post_rst_halt", 0,1,0,32'h2000_0000, e_h, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
